// File: rtl/lsu_mem_stage_pkg.sv
// Shared opcode / funct3 constants and the access legality check for the LSU.
package lsu_mem_stage_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;
    localparam logic [2:0] FNC_SB  = 3'b000;
    localparam logic [2:0] FNC_SH  = 3'b001;
    localparam logic [2:0] FNC_SW  = 3'b010;

    // Returns 1 when the access must not reach memory: an undefined funct3
    // for the access kind, or a halfword/word address that is not aligned.
    function automatic logic access_fault(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic legal;
        logic fault;
        if (is_store) begin
            legal = (funct3 == FNC_SB) || (funct3 == FNC_SH) || (funct3 == FNC_SW);
        end else begin
            legal = (funct3 == FNC_LB) || (funct3 == FNC_LH) || (funct3 == FNC_LW) ||
                    (funct3 == FNC_LBU) || (funct3 == FNC_LHU);
        end
        case (funct3[1:0])
            2'b01:   fault = offset[0];
            2'b10:   fault = (offset != 2'b00);
            default: fault = 1'b0;
        endcase
        return !legal || fault;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Byte-lane steering: store mask/data replication and load extraction/extension.
module lsu_align
    import lsu_mem_stage_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic        we_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_word_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [31:0] shifted;

    // Store side: replicate the datum across lanes and enable only the target bytes.
    always_comb begin
        wmask_o = 4'b0000;
        wdata_o = store_data_i;
        if (we_i) begin
            case (funct3_i)
                FNC_SB: begin
                    wmask_o = 4'b0001 << offset_i;
                    wdata_o = {4{store_data_i[7:0]}};
                end
                FNC_SH: begin
                    wmask_o = 4'b0011 << offset_i;
                    wdata_o = {2{store_data_i[15:0]}};
                end
                default: begin
                    wmask_o = 4'b1111;
                    wdata_o = store_data_i;
                end
            endcase
        end
    end

    // Load side: bring the addressed byte/halfword to bit 0, then extend.
    always_comb begin
        shifted     = load_word_i >> {offset_i, 3'b000};
        load_data_o = load_word_i;
        case (funct3_i)
            FNC_LB:  load_data_o = {{24{shifted[7]}}, shifted[7:0]};
            FNC_LH:  load_data_o = {{16{shifted[15]}}, shifted[15:0]};
            FNC_LBU: load_data_o = {24'd0, shifted[7:0]};
            FNC_LHU: load_data_o = {16'd0, shifted[15:0]};
            default: load_data_o = load_word_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit: accepts EX-stage memory ops, runs a valid/ready memory
// transaction with a response timeout, and stalls the pipeline until done.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        ex_valid,
    input  logic [6:0]  ex_opcode,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        result_valid,
    output logic [31:0] result_data,
    output logic        misalign_fault,
    output logic        bus_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q,  state_d;
    logic [31:0]       addr_q,   addr_d;
    logic [31:0]       wdata_q,  wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              we_q,     we_d;
    logic [TO_W-1:0]   cnt_q,    cnt_d;
    logic [31:0]       result_q, result_d;
    logic              fault_q,  fault_d;
    logic              buserr_q, buserr_d;

    logic              mem_op;
    logic              is_store;
    logic [31:0]       load_data;

    assign is_store = (ex_opcode == OPC_STORE);
    assign mem_op   = ex_valid && ((ex_opcode == OPC_LOAD) || is_store);

    lsu_align u_align (
        .funct3_i     (funct3_q),
        .offset_i     (addr_q[1:0]),
        .we_i         (we_q),
        .store_data_i (wdata_q),
        .load_word_i  (mem_resp_data),
        .wmask_o      (mem_wmask),
        .wdata_o      (mem_wdata),
        .load_data_o  (load_data)
    );

    assign mem_addr       = {addr_q[31:2], 2'b00};
    assign mem_we         = we_q;
    // Completion fields are only meaningful during the DONE pulse.
    assign result_data    = (state_q == ST_DONE) ? result_q : 32'd0;
    assign misalign_fault = (state_q == ST_DONE) && fault_q;
    assign bus_err        = (state_q == ST_DONE) && buserr_q;

    // Next-state, handshake and stall logic.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        funct3_d      = funct3_q;
        we_d          = we_q;
        cnt_d         = cnt_q;
        result_d      = result_q;
        fault_d       = fault_q;
        buserr_d      = buserr_q;
        stall         = 1'b0;
        mem_req_valid = 1'b0;
        result_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall = mem_op;
                if (mem_op) begin
                    result_d = 32'd0;
                    buserr_d = 1'b0;
                    if (access_fault(is_store, ex_funct3, ex_addr[1:0])) begin
                        // Faulting accesses never reach the bus.
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        fault_d  = 1'b0;
                        addr_d   = ex_addr;
                        wdata_d  = ex_wdata;
                        funct3_d = ex_funct3;
                        we_d     = is_store;
                        state_d  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                // A response in the final timeout cycle still counts as success.
                if (mem_resp_valid) begin
                    result_d = we_q ? 32'd0 : load_data;
                    state_d  = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    buserr_d = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            default: begin
                result_valid = 1'b1;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            result_q <= 32'd0;
            fault_q  <= 1'b0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            fault_q  <= fault_d;
            buserr_q <= buserr_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed testbench for lsu_mem_stage.
module tb_lsu_mem_stage;
    import lsu_mem_stage_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        result_valid;
    logic [31:0] result_data;
    logic        misalign_fault;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    // Observations from the most recent do_op call.
    int          obs_stalls;
    int          obs_req_cycles;
    logic        obs_done, obs_mf, obs_be, obs_stable, obs_we;
    logic        obs_after_rv, obs_after_stall, obs_after_req;
    logic [31:0] obs_rd, obs_addr, obs_wdata;
    logic [3:0]  obs_mask;

    always #5 Clock = ~Clock;

    lsu_mem_stage #(.TIMEOUT_CYCLES(64), .TO_W(7)) dut (
        .Clock          (Clock),
        .Reset_n        (Reset_n),
        .ex_valid       (ex_valid),
        .ex_opcode      (ex_opcode),
        .ex_funct3      (ex_funct3),
        .ex_addr        (ex_addr),
        .ex_wdata       (ex_wdata),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wmask      (mem_wmask),
        .mem_wdata      (mem_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .result_valid   (result_valid),
        .result_data    (result_data),
        .misalign_fault (misalign_fault),
        .bus_err        (bus_err)
    );

    // Presents one instruction and plays the memory side: ready after
    // ready_delay REQ cycles, response in WAIT cycle resp_delay (-1 = never).
    // Records what the DUT did; the calling test does the comparisons.
    task automatic do_op(input logic [6:0] opc, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input int ready_delay, input int resp_delay,
                         input logic [31:0] rdata);
        int   req_idx  = 0;
        int   wait_idx = 0;
        logic accepted = 1'b0;
        bit   fin      = 1'b0;
        obs_stalls = 0; obs_done = 0; obs_mf = 0; obs_be = 0; obs_stable = 1;
        obs_rd = 32'd0; obs_addr = 32'd0; obs_wdata = 32'd0; obs_mask = 4'd0; obs_we = 0;
        ex_valid = 1'b1; ex_opcode = opc; ex_funct3 = f3; ex_addr = addr; ex_wdata = rs2;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = rdata;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            #1;
            if (result_valid) begin
                obs_done = 1'b1; obs_rd = result_data; obs_mf = misalign_fault; obs_be = bus_err;
                ex_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
                fin = 1'b1;
            end else begin
                if (stall) obs_stalls++;
                mem_resp_valid = 1'b0;
                if (accepted) begin
                    mem_resp_valid = (resp_delay >= 0) && (wait_idx == resp_delay);
                    wait_idx++;
                end
                if (mem_req_valid) begin
                    if (req_idx == 0) begin
                        obs_addr = mem_addr; obs_mask = mem_wmask; obs_wdata = mem_wdata; obs_we = mem_we;
                    end else if (mem_addr !== obs_addr || mem_wmask !== obs_mask ||
                                 mem_wdata !== obs_wdata || mem_we !== obs_we) begin
                        obs_stable = 1'b0;
                    end
                    mem_req_ready = (req_idx >= ready_delay);
                    req_idx++;
                    if (mem_req_ready) begin
                        accepted = 1'b1;
                        wait_idx = 0;
                    end
                end else begin
                    mem_req_ready = 1'b0;
                end
                @(posedge Clock); @(negedge Clock);
            end
        end
        obs_req_cycles = req_idx;
        @(posedge Clock); @(negedge Clock); #1;
        obs_after_rv = result_valid; obs_after_stall = stall; obs_after_req = mem_req_valid;
    endtask

    task automatic test_reset();
        @(negedge Clock); #1;
        checks++;
        if ({stall, mem_req_valid, result_valid, misalign_fault, bus_err, mem_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got stall/req/rv/mf/be/we=%b required 000000",
                     {stall, mem_req_valid, result_valid, misalign_fault, bus_err, mem_we});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_wmask, result_data} !== 100'd0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h mask=%b rd=%h required all zero",
                     mem_addr, mem_wdata, mem_wmask, result_data);
        end
        Reset_n = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_store_word();
        do_op(OPC_STORE, FNC_SW, 32'h1000_0004, 32'hDEAD_BEEF, 0, 0, 32'h0);
        checks++;
        if (obs_done !== 1'b1) begin errors++; $display("FAIL sw_done: got %b required 1", obs_done); end
        checks++;
        if ({obs_addr, obs_mask, obs_wdata, obs_we} !== {32'h1000_0004, 4'b1111, 32'hDEAD_BEEF, 1'b1}) begin
            errors++;
            $display("FAIL sw_req: got addr=%h mask=%b wdata=%h we=%b required 10000004 1111 deadbeef 1",
                     obs_addr, obs_mask, obs_wdata, obs_we);
        end
        checks++;
        if (obs_stalls !== 3) begin errors++; $display("FAIL sw_stalls: got %0d required 3", obs_stalls); end
        checks++;
        if ({obs_rd, obs_mf, obs_be} !== 34'd0) begin
            errors++; $display("FAIL sw_result: got rd=%h mf=%b be=%b required 0 0 0", obs_rd, obs_mf, obs_be);
        end
        checks++;
        if (obs_after_rv !== 1'b0) begin errors++; $display("FAIL sw_pulse: got rv=%b after DONE required 0", obs_after_rv); end
        $display("sw   addr=%h stalls=%0d rd=%h", obs_addr, obs_stalls, obs_rd);
    endtask

    task automatic test_load_extract();
        logic [2:0]  f3s   [7] = '{FNC_LB, FNC_LBU, FNC_LH, FNC_LHU, FNC_LW, FNC_LB, FNC_LBU};
        logic [31:0] addrs [7] = '{32'h2000_0003, 32'h2000_0003, 32'h2000_0002, 32'h2000_0002,
                                   32'h2000_0000, 32'h2000_0002, 32'h2000_0001};
        logic [31:0] exps  [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF,
                                   32'h80FF_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        for (int i = 0; i < 7; i++) begin
            do_op(OPC_LOAD, f3s[i], addrs[i], 32'h0, 0, 0, 32'h80FF_0000);
            checks++;
            if (obs_done !== 1'b1 || obs_rd !== exps[i]) begin
                errors++;
                $display("FAIL load_%0d: got done=%b rd=%h required 1 %h", i, obs_done, obs_rd, exps[i]);
            end
            checks++;
            if (obs_addr !== {addrs[i][31:2], 2'b00} || obs_mask !== 4'b0000 || obs_we !== 1'b0) begin
                errors++;
                $display("FAIL load_req_%0d: got addr=%h mask=%b we=%b required %h 0000 0",
                         i, obs_addr, obs_mask, obs_we, {addrs[i][31:2], 2'b00});
            end
            $display("load f3=%b addr=%h rd=%h", f3s[i], addrs[i], obs_rd);
        end
    endtask

    task automatic test_store_lanes();
        logic [2:0]  f3s   [4] = '{FNC_SH, FNC_SB, FNC_SB, FNC_SH};
        logic [31:0] addrs [4] = '{32'h3000_0002, 32'h3000_0001, 32'h3000_0003, 32'h3000_0000};
        logic [31:0] rs2s  [4] = '{32'h1234_ABCD, 32'h0000_0055, 32'hFFFF_FFA7, 32'h0000_BEEF};
        logic [3:0]  masks [4] = '{4'b1100, 4'b0010, 4'b1000, 4'b0011};
        logic [31:0] wds   [4] = '{32'hABCD_ABCD, 32'h5555_5555, 32'hA7A7_A7A7, 32'hBEEF_BEEF};
        for (int i = 0; i < 4; i++) begin
            do_op(OPC_STORE, f3s[i], addrs[i], rs2s[i], 0, 0, 32'h0);
            checks++;
            if (obs_done !== 1'b1 || obs_mask !== masks[i] || obs_wdata !== wds[i] || obs_rd !== 32'd0) begin
                errors++;
                $display("FAIL store_lane_%0d: got done=%b mask=%b wdata=%h rd=%h required 1 %b %h 0",
                         i, obs_done, obs_mask, obs_wdata, obs_rd, masks[i], wds[i]);
            end
            $display("store f3=%b addr=%h mask=%b wdata=%h", f3s[i], addrs[i], obs_mask, obs_wdata);
        end
    endtask

    task automatic test_misalign();
        logic [6:0]  opcs  [5] = '{OPC_LOAD, OPC_LOAD, OPC_STORE, OPC_LOAD, OPC_STORE};
        logic [2:0]  f3s   [5] = '{FNC_LH, FNC_LW, FNC_SW, 3'b011, 3'b100};
        logic [31:0] addrs [5] = '{32'h3000_0001, 32'h3000_0002, 32'h3000_0001, 32'h3000_0000, 32'h3000_0000};
        for (int i = 0; i < 5; i++) begin
            do_op(opcs[i], f3s[i], addrs[i], 32'h5A5A_5A5A, 0, 0, 32'hFFFF_FFFF);
            checks++;
            if (obs_done !== 1'b1 || obs_mf !== 1'b1 || obs_be !== 1'b0 || obs_rd !== 32'd0) begin
                errors++;
                $display("FAIL misalign_%0d: got done=%b mf=%b be=%b rd=%h required 1 1 0 0",
                         i, obs_done, obs_mf, obs_be, obs_rd);
            end
            checks++;
            if (obs_req_cycles !== 0 || obs_stalls !== 1) begin
                errors++;
                $display("FAIL misalign_bus_%0d: got req_cycles=%0d stalls=%0d required 0 1",
                         i, obs_req_cycles, obs_stalls);
            end
            $display("fault opc=%h f3=%b addr=%h mf=%b", opcs[i], f3s[i], addrs[i], obs_mf);
        end
    endtask

    task automatic test_backpressure();
        do_op(OPC_LOAD, FNC_LW, 32'h4000_0008, 32'h0, 5, 0, 32'hCAFE_F00D);
        checks++;
        if (obs_req_cycles !== 6 || obs_stable !== 1'b1) begin
            errors++;
            $display("FAIL bp_req: got req_cycles=%0d stable=%b required 6 1", obs_req_cycles, obs_stable);
        end
        checks++;
        if (obs_done !== 1'b1 || obs_rd !== 32'hCAFE_F00D || obs_stalls !== 8) begin
            errors++;
            $display("FAIL bp_result: got done=%b rd=%h stalls=%0d required 1 cafef00d 8",
                     obs_done, obs_rd, obs_stalls);
        end
        $display("bp   req_cycles=%0d rd=%h", obs_req_cycles, obs_rd);
    endtask

    task automatic test_timeout();
        do_op(OPC_LOAD, FNC_LW, 32'h4000_0010, 32'h0, 0, -1, 32'h1234_5678);
        checks++;
        if (obs_done !== 1'b1 || obs_be !== 1'b1 || obs_mf !== 1'b0 || obs_rd !== 32'd0) begin
            errors++;
            $display("FAIL timeout_flags: got done=%b be=%b mf=%b rd=%h required 1 1 0 0",
                     obs_done, obs_be, obs_mf, obs_rd);
        end
        checks++;
        if (obs_stalls !== 66) begin errors++; $display("FAIL timeout_len: got stalls=%0d required 66", obs_stalls); end
        checks++;
        if ({obs_after_rv, obs_after_stall, obs_after_req} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_idle: got rv/stall/req=%b required 000",
                     {obs_after_rv, obs_after_stall, obs_after_req});
        end
        $display("tmo  stalls=%0d be=%b", obs_stalls, obs_be);
        // Response in the last allowed WAIT cycle beats the timeout.
        do_op(OPC_LOAD, FNC_LW, 32'h4000_0014, 32'h0, 0, 63, 32'h1122_3344);
        checks++;
        if (obs_done !== 1'b1 || obs_be !== 1'b0 || obs_rd !== 32'h1122_3344 || obs_stalls !== 66) begin
            errors++;
            $display("FAIL tie: got done=%b be=%b rd=%h stalls=%0d required 1 0 11223344 66",
                     obs_done, obs_be, obs_rd, obs_stalls);
        end
        $display("tie  stalls=%0d rd=%h be=%b", obs_stalls, obs_rd, obs_be);
    endtask

    task automatic test_non_mem();
        logic bad = 1'b0;
        ex_valid = 1'b1; ex_opcode = 7'b0110011; ex_funct3 = FNC_LW; ex_addr = 32'h100; ex_wdata = 32'h0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (stall || mem_req_valid || result_valid) bad = 1'b1;
            @(posedge Clock); @(negedge Clock);
            ex_opcode = (i == 1) ? OPC_LOAD : 7'b0110011;
            ex_valid  = (i != 1);
        end
        ex_valid = 1'b0; mem_resp_valid = 1'b0;
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL non_mem: got activity=%b required 0", bad); end
        $display("nonmem activity=%b", bad);
    endtask

    task automatic test_reset_mid_op();
        logic seen_rv = 1'b0;
        @(negedge Clock);
        ex_valid = 1'b1; ex_opcode = OPC_LOAD; ex_funct3 = FNC_LW; ex_addr = 32'h5000_0000;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
        @(posedge Clock); @(negedge Clock);
        @(posedge Clock); @(negedge Clock); #1;
        checks++;
        if (stall !== 1'b1 || mem_req_valid !== 1'b0 || mem_addr !== 32'h5000_0000) begin
            errors++;
            $display("FAIL rst_pre: got stall=%b req=%b addr=%h required 1 0 50000000", stall, mem_req_valid, mem_addr);
        end
        Reset_n = 1'b0; ex_valid = 1'b0; mem_req_ready = 1'b0;
        #1;
        checks++;
        if ({stall, mem_req_valid, result_valid, mem_addr, mem_wmask, result_data} !== 71'd0) begin
            errors++;
            $display("FAIL rst_async: got stall=%b req=%b rv=%b addr=%h mask=%b rd=%h required all zero",
                     stall, mem_req_valid, result_valid, mem_addr, mem_wmask, result_data);
        end
        @(negedge Clock);
        Reset_n = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'h7777_7777;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clock); @(negedge Clock); #1;
            mem_resp_valid = 1'b0;
            if (result_valid || stall) seen_rv = 1'b1;
        end
        checks++;
        if (seen_rv !== 1'b0) begin errors++; $display("FAIL rst_stray: got result/stall activity=%b required 0", seen_rv); end
        $display("rst  stray_activity=%b", seen_rv);
    endtask

    initial begin
        Reset_n = 1'b0; ex_valid = 1'b0; ex_opcode = 7'd0; ex_funct3 = 3'd0; ex_addr = 32'd0;
        ex_wdata = 32'd0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'd0;
        test_reset();
        test_store_word();
        test_load_extract();
        test_store_lanes();
        test_misalign();
        test_backpressure();
        test_timeout();
        test_non_mem();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Load/store unit sitting directly downstream of the execute-stage ALU. It takes the ALU result as the effective address for OPC_LOAD / OPC_STORE instructions, which the ALU computes as A + B. It drives a valid/ready data-memory request port, with byte-lane shifting and masking for stores and sign/zero extraction for loads. It stalls the pipeline until the access completes, faults, or times out.

Parameters:
TIMEOUT_CYCLES, 64, cycles spent in WAIT before a bus error is declared (minimum 2).
TO_W, 7, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
Clock  in  1  system clock, rising edge.
Reset_n  in  1  asynchronous active-low reset.
ex_valid  in  1  execute stage holds a valid instruction.
ex_opcode  in  7  instruction opcode; only OPC_LOAD and OPC_STORE are acted on.
ex_funct3  in  3  access size and sign.
ex_addr  in  32  ALU result, the effective address.
ex_wdata  in  32  rs2 value (store data).
stall  out  1  freezes the upstream pipeline.
mem_req_valid  out  1  request valid.
mem_req_ready  in  1  memory accepts the request.
mem_we  out  1  1 = store.
mem_addr  out  32  word address, {ex_addr[31:2], 2'b00}.
mem_wmask  out  4  byte-enable mask.
mem_wdata  out  32  lane-shifted store data.
mem_resp_valid  in  1  response or write-ack.
mem_resp_data  in  32  read word.
result_valid  out  1  one-cycle completion pulse.
result_data  out  32  extended load value; 0 for stores and faults.
misalign_fault  out  1  qualifies result_valid.
bus_err  out  1  qualifies result_valid.

Behaviour:
- The clock is Clock. Reset is Reset_n: asynchronous, active-low. All flops clear on reset.
- Reset values: state=IDLE; mem_req_valid, result_valid, misalign_fault and bus_err = 0; result_data, mem_addr, mem_wdata and mem_wmask = 0. stall=0 unless the IDLE accept condition below holds.
- Memory op: ex_valid && (ex_opcode==OPC_LOAD || ex_opcode==OPC_STORE).
- Legal funct3 values:
  - Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - Stores: SB=000, SH=001, SW=010.
  - Any other funct3 is treated as a misaligned fault.
- Alignment rules:
  - Halfword access requires addr[0]==0.
  - Word access requires addr[1:0]==00.
  - Byte access is always aligned.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - stall = memory op, combinational.
  - Aligned memory op: latch address, data, funct3 and we; go to REQ.
  - Misaligned memory op: go to DONE with the fault flag set. No memory request is issued.
- REQ:
  - mem_req_valid=1; request fields are stable while waiting.
  - On mem_req_ready, go to WAIT and clear the timeout counter.
  - stall=1.
- WAIT:
  - stall=1; the counter increments every cycle.
  - On mem_resp_valid: capture the data and go to DONE.
  - When the counter reaches TIMEOUT_CYCLES-1 with no response: go to DONE with the bus_err flag set.
  - If a response and the timeout occur in the same cycle, the response wins.
- DONE:
  - result_valid=1 and stall=0, so the pipeline advances at this edge.
  - Unconditionally return to IDLE; the instruction is never re-accepted.
- A mem_resp_valid arriving in IDLE, REQ or DONE is ignored.
- Store lane rules:
  - SB: wmask = 0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: wmask = 0011 << addr[1:0]; wdata = {2{rs2[15:0]}}.
  - SW: wmask = 1111; wdata = rs2.
  - Loads: wmask = 0000.
- Load extraction:
  - Select the byte or halfword at addr[1:0] from mem_resp_data.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Latency with ready=1 and the response one cycle after acceptance: 3 stall cycles, then the DONE cycle.
- Reset mid-operation: return to IDLE immediately. Any later response for the abandoned request is ignored.

Decomposition:
- Opcode.vh (shared header) gains funct3 constants: FNC_LB, FNC_LH, FNC_LW, FNC_LBU, FNC_LHU, FNC_SB, FNC_SH, FNC_SW.
- State encodings are local to the module.
- One combinational sub-module, lsu_align, performs store shift/mask generation and load extraction/extension. The FSM and counter stay in lsu_mem_stage.

Test Plan:
1. SW, addr=0x1000_0004, rs2=0xDEADBEEF, ready=1, ack one cycle after acceptance → mem_addr=0x1000_0004, wmask=1111, wdata=0xDEADBEEF; stall high 3 cycles; result_valid pulses with result_data=0.
2. LB, addr=0x...03, resp_data=0x80FF_0000 → result_data=0xFFFFFF80. LBU with the same stimulus → 0x00000080.
3. SH, addr=0x...02, rs2=0x1234_ABCD → wmask=1100, wdata=0xABCDABCD. LH, addr=0x...01 → misalign_fault=1 with result_valid, no mem_req_valid ever, stall exactly 1 cycle.
4. LW, ready held low 5 cycles → mem_req_valid and mem_addr stable for all 5 cycles; the request completes normally after ready rises.
5. LW with no response, TIMEOUT_CYCLES=64 → bus_err=1 with result_valid after 64 WAIT cycles; back in IDLE on the next cycle.
6. Reset_n pulsed low in WAIT, then a stray resp_valid → outputs at reset values immediately; the stray response produces no result_valid.
